// File: rtl/alu_muldiv_ctrl_pkg.sv
// Shared opcode, state and sizing definitions for the mul/div unit and the ALU decode.
package alu_muldiv_ctrl_pkg;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [4:0] {
    OP_MUL    = 5'b01000,
    OP_MULH   = 5'b01001,
    OP_MULHSU = 5'b01010,
    OP_MULHU  = 5'b01011,
    OP_DIV    = 5'b01100,
    OP_REM    = 5'b01101,
    OP_DIVU   = 5'b01110,
    OP_REMU   = 5'b01111
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Captured request; only the low opcode bits matter once the FSM knows mul vs div.
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  // Opcode group select[4:3]; 01 marks the mul/div extension.
  function automatic logic is_muldiv(input logic [1:0] grp);
    return grp == 2'b01;
  endfunction

  // kind: 00 low word, 01 s*s high, 10 s*u high, 11 u*u high.
  function automatic logic [31:0] mul_result(input logic [1:0] kind,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = {{32{a[31] & (kind == 2'b01 || kind == 2'b10)}}, a};
    eb = {{32{b[31] & (kind == 2'b01)}}, b};
    p  = ea * eb;
    return (kind == 2'b00) ? p[31:0] : p[63:32];
  endfunction

endpackage

// File: rtl/alu_muldiv_ctrl_if.sv
// Request/response bundle between the issue pipeline and the mul/div unit.
interface alu_muldiv_ctrl_if;
  logic        start;
  logic [4:0]  select;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        flush;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  modport master (
    output start, select, data1, data2, flush,
    input  busy, valid, result
  );

  modport slave (
    input  start, select, data1, data2, flush,
    output busy, valid, result
  );
endinterface

// File: rtl/div_iter.sv
// Restoring radix-2 divider core on unsigned magnitudes: load once, then one quotient bit per step.
module div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] dvs_q;
  logic [32:0] trial;

  // Shift the next dividend bit into the partial remainder and try the subtract.
  always_comb begin
    trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= {quo_q[30:0], ~trial[32]};
      rem_q <= trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// Mul/div unit: FSM, fixed-latency multiply path and control around the iterative divider.
// Divide setup happens in the accept cycle; specials (x/0, INT_MIN/-1) complete in one cycle.
module alu_muldiv_ctrl
  import alu_muldiv_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  alu_muldiv_ctrl_if.slave   bus
);

  localparam logic [5:0] MUL_LAST_CNT = (MUL_LATENCY >= 2) ? 6'(MUL_LATENCY - 2) : 6'd0;
  localparam logic [5:0] DIV_LAST_CNT = 6'(DIV_CYCLES);

  state_t      state;
  state_t      state_nxt;
  req_t        req_q;
  logic [5:0]  cnt;
  logic [31:0] result_q;
  logic [31:0] result_nxt;
  logic        valid_q;

  logic        accept;
  logic        req_is_div;
  logic        req_signed;
  logic        div_zero;
  logic        div_ovf;
  logic        req_special;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        div_load;
  logic        div_step;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        q_neg;
  logic        r_neg;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // Request decode works on the live inputs; only used in the accept cycle.
  always_comb begin
    accept      = bus.start && !bus.flush && is_muldiv(bus.select[4:3]) &&
                  (state == ST_IDLE || state == ST_DONE);
    req_is_div  = bus.select[2];
    req_signed  = !bus.select[1];
    div_zero    = (bus.data2 == 32'h0000_0000);
    div_ovf     = req_signed && (bus.data1 == 32'h8000_0000) && (bus.data2 == 32'hFFFF_FFFF);
    req_special = req_is_div && (div_zero || div_ovf);
    abs_a       = (req_signed && bus.data1[31]) ? -bus.data1 : bus.data1;
    abs_b       = (req_signed && bus.data2[31]) ? -bus.data2 : bus.data2;
    div_load    = accept && req_is_div && !req_special;
    div_step    = (state == ST_DIV) && (cnt < DIV_LAST_CNT);
  end

  div_iter u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (req_special)           state_nxt = ST_DONE;
          else if (req_is_div)       state_nxt = ST_DIV;
          else if (MUL_LATENCY <= 1) state_nxt = ST_DONE;
          else                       state_nxt = ST_MUL;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (bus.flush)                 state_nxt = ST_IDLE;
        else if (cnt == MUL_LAST_CNT)  state_nxt = ST_DONE;
      end
      ST_DIV: begin
        if (bus.flush)                 state_nxt = ST_IDLE;
        else if (cnt == DIV_LAST_CNT)  state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Sign fixup: quotient negative on differing signs, remainder follows the dividend.
  always_comb begin
    q_neg = !req_q.kind[1] && (req_q.a[31] ^ req_q.b[31]);
    r_neg = !req_q.kind[1] && req_q.a[31];
    q_fix = q_neg ? -quo : quo;
    r_fix = r_neg ? -rem : rem;

    result_nxt = result_q;
    if (accept && req_special) begin
      if (div_zero) result_nxt = bus.select[0] ? bus.data1 : 32'hFFFF_FFFF;
      else          result_nxt = bus.select[0] ? 32'h0000_0000 : 32'h8000_0000;
    end else if (accept && !req_is_div && (MUL_LATENCY <= 1)) begin
      result_nxt = mul_result(bus.select[1:0], bus.data1, bus.data2);
    end else if (state == ST_MUL) begin
      result_nxt = mul_result(req_q.kind, req_q.a, req_q.b);
    end else if (state == ST_DIV) begin
      result_nxt = req_q.kind[0] ? r_fix : q_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q    <= '0;
      cnt      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      // DONE is only ever entered on a fresh completion, so this is a true pulse.
      valid_q <= (state_nxt == ST_DONE);
      if (state_nxt == ST_DONE) begin
        result_q <= result_nxt;
      end
      if (accept) begin
        req_q.kind <= bus.select[1:0];
        req_q.a    <= bus.data1;
        req_q.b    <= bus.data2;
        cnt        <= '0;
      end else if (state == ST_MUL || state == ST_DIV) begin
        cnt <= cnt + 6'd1;
      end
    end
  end

  assign bus.busy   = (state == ST_MUL) || (state == ST_DIV);
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Randomized and directed bench for alu_muldiv_ctrl against an arithmetic reference model.
module tb_alu_muldiv_ctrl;

  localparam int MUL_LAT = 2;
  localparam logic [4:0] C_MUL    = 5'b01000;
  localparam logic [4:0] C_MULH   = 5'b01001;
  localparam logic [4:0] C_MULHSU = 5'b01010;
  localparam logic [4:0] C_MULHU  = 5'b01011;
  localparam logic [4:0] C_DIV    = 5'b01100;
  localparam logic [4:0] C_REM    = 5'b01101;
  localparam logic [4:0] C_DIVU   = 5'b01110;
  localparam logic [4:0] C_REMU   = 5'b01111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_muldiv_ctrl_if bus();

  alu_muldiv_ctrl #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      C_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
      C_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      C_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      C_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      C_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      C_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      C_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      C_REMU:   return (b == 0) ? a : a % b;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op == C_MUL || op == C_MULH || op == C_MULHSU || op == C_MULHU) return MUL_LAT;
    if (b == 0) return 1;
    if ((op == C_DIV || op == C_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'($urandom_range(0, 20));
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Drive START for one cycle from a negedge; returns at the negedge of cycle 1.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.select = op;
    bus.data1  = a;
    bus.data2  = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.select = 5'($urandom);
    bus.data1  = $urandom;
    bus.data2  = $urandom;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (bus.valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy1,
                        output logic valid_next, output logic [31:0] res_next);
    @(negedge clk);
    issue(op, a, b);
    busy1 = bus.busy;
    wait_valid(lat);
    res = bus.result;
    @(negedge clk);
    valid_next = bus.valid;
    res_next   = bus.result;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.flush = 1'b0; bus.select = 5'h0; bus.data1 = '0; bus.data2 = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.result); end
  endtask

  task automatic test_directed();
    logic [4:0]  ops [10];
    logic [31:0] as  [10];
    logic [31:0] bs  [10];
    logic [31:0] exp [10];
    int          lats[10];
    logic [31:0] res, res_n;
    logic        busy1, vn;
    int          lat;
    ops = '{C_MUL, C_MULHU, C_DIV, C_REM, C_DIVU, C_REMU, C_DIVU, C_REMU, C_DIV, C_REM};
    as  = '{32'h7, 32'h7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
            32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
    bs  = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd2, 32'd2, 32'd7, 32'd7,
            32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exp = '{32'hFFFF_FFEB, 32'h6, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
            32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0};
    lats = '{2, 2, 34, 34, 34, 34, 1, 1, 1, 1};
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, busy1, vn, res_n);
      n_checks++; if (res !== exp[i]) begin n_fail++; $display("FAIL directed_result[%0d]: got %h want %h", i, res, exp[i]); end
      n_checks++; if (lat !== lats[i]) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, lats[i]); end
      n_checks++; if (busy1 !== (lats[i] > 1)) begin n_fail++; $display("FAIL directed_busy[%0d]: got %b want %b", i, busy1, lats[i] > 1); end
      n_checks++; if (vn !== 1'b0) begin n_fail++; $display("FAIL directed_pulse[%0d]: valid still %b", i, vn); end
      n_checks++; if (res_n !== exp[i]) begin n_fail++; $display("FAIL directed_hold[%0d]: got %h want %h", i, res_n, exp[i]); end
    end
  endtask

  task automatic test_random(input int n, input logic [2:0] grp);
    logic [4:0]  op;
    logic [31:0] a, b, res, res_n;
    logic        busy1, vn;
    int          lat;
    for (int i = 0; i < n; i++) begin
      op = {grp, 2'($urandom_range(0, 3))};
      a  = rand_operand();
      b  = rand_operand();
      run_op(op, a, b, res, lat, busy1, vn, res_n);
      n_checks++; if (res !== ref_result(op, a, b)) begin n_fail++; $display("FAIL random_result op=%b a=%h b=%h: got %h want %h", op, a, b, res, ref_result(op, a, b)); end
      n_checks++; if (lat !== ref_latency(op, a, b)) begin n_fail++; $display("FAIL random_latency op=%b a=%h b=%h: got %0d want %0d", op, a, b, lat, ref_latency(op, a, b)); end
    end
  endtask

  task automatic test_invalid_select();
    logic [4:0] bad [4];
    int seen;
    bad = '{5'b00000, 5'b10100, 5'b11111, 5'b00110};
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.select = bad[i]; bus.data1 = $urandom; bus.data2 = $urandom;
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) begin
      if (bus.busy !== 1'b0 || bus.valid !== 1'b0) seen++;
      @(negedge clk);
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL invalid_select: activity in %0d cycles, want 0", seen); end
  endtask

  task automatic test_flush();
    logic [31:0] res, res_n;
    logic        busy1, vn;
    int          lat, cyc, seen;
    run_op(C_MUL, 32'h7, 32'hFFFF_FFFD, res, lat, busy1, vn, res_n);
    @(negedge clk);
    issue(C_DIV, 32'd1000, 32'd3);
    cyc = 1;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", bus.valid); end
    n_checks++; if (bus.result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL flush_result: got %h want ffffffeb", bus.result); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.valid === 1'b1) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_valid: got %0d pulses want 0", seen); end
    bus.start = 1'b1; bus.flush = 1'b1; bus.select = C_MUL; bus.data1 = 32'd3; bus.data2 = 32'd5;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b want 0", bus.busy); end
    seen = 0;
    repeat (5) begin @(negedge clk); if (bus.valid === 1'b1) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_start_valid: got %0d pulses want 0", seen); end
    n_checks++; if (bus.result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL flush_start_result: got %h want ffffffeb", bus.result); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    @(negedge clk);
    issue(C_DIVU, 32'd1000, 32'd7);
    cyc = 1;
    while (bus.valid !== 1'b1 && cyc < 200) begin
      bus.start = (cyc == 5);
      if (cyc == 5) begin bus.select = C_MUL; bus.data1 = 32'd3; bus.data2 = 32'd5; end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL busy_ignore_latency: got %0d want 34", cyc); end
    n_checks++; if (bus.result !== 32'd142) begin n_fail++; $display("FAIL busy_ignore_result: got %h want %h", bus.result, 32'd142); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops [4];
    logic [31:0] as  [4];
    logic [31:0] bs  [4];
    int          cyc;
    ops = '{C_MUL, C_DIVU, C_REMU, C_MULHU};
    as  = '{32'h7, 32'd100, 32'h1234_5678, 32'h7};
    bs  = '{32'hFFFF_FFFD, 32'd7, 32'h0, 32'hFFFF_FFFD};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_valid(cyc);
      n_checks++; if (cyc !== ref_latency(ops[i], as[i], bs[i])) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, cyc, ref_latency(ops[i], as[i], bs[i])); end
      n_checks++; if (bus.result !== ref_result(ops[i], as[i], bs[i])) begin n_fail++; $display("FAIL b2b_result[%0d]: got %h want %h", i, bus.result, ref_result(ops[i], as[i], bs[i])); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] res, res_n;
    logic        busy1, vn;
    int          lat, cyc, seen;
    @(negedge clk);
    issue(C_DIV, 32'hFFFF_FFF9, 32'd2);
    cyc = 1;
    while (cyc < 20) begin @(negedge clk); cyc++; end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_valid: got %b want 0", bus.valid); end
    n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_mid_result: got %h want 0", bus.result); end
    seen = 0;
    repeat (20) begin @(negedge clk); if (bus.valid === 1'b1) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL reset_mid_no_valid: got %0d pulses want 0", seen); end
    run_op(C_MUL, 32'h7, 32'hFFFF_FFFD, res, lat, busy1, vn, res_n);
    n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL reset_mid_mul_result: got %h want ffffffeb", res); end
    n_checks++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL reset_mid_mul_latency: got %0d want %0d", lat, MUL_LAT); end
  endtask

  initial begin
    bus.start = 1'b0; bus.flush = 1'b0; bus.select = 5'h0; bus.data1 = '0; bus.data2 = '0;
    test_reset();
    test_directed();
    test_random(16, 3'b010);
    test_random(10, 3'b011);
    test_invalid_select();
    test_flush();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_ctrl.md
ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

Interface
REQ-001 Parameter MUL_LATENCY, default 2, cycles from accepted START to VALID for MUL/MULH/MULHSU/MULHU; legal range 1..4.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request to begin one mul/div operation this cycle.
REQ-005 SELECT  input  5  operation code: 01000 MUL, 01001 MULH, 01010 MULHSU, 01011 MULHU, 01100 DIV, 01101 REM, 01110 DIVU, 01111 REMU.
REQ-006 DATA1  input  32  dividend / multiplicand (rs1).
REQ-007 DATA2  input  32  divisor / multiplier (rs2).
REQ-008 FLUSH  input  1  abort the in-flight operation (pipeline flush).
REQ-009 BUSY  output  1  high while an operation is in flight; drives pipeline stall.
REQ-010 VALID  output  1  one-cycle pulse marking RESULT as the completed operation.
REQ-011 RESULT  output  32  completed result; held stable from VALID until the next accepted START.

Function
REQ-012 States IDLE, MUL, DIV, DONE; START accepted only in IDLE or DONE with SELECT[4:3]=01 and FLUSH low.
REQ-013 START with any other SELECT, or while BUSY, shall be ignored with no state change.
REQ-014 DATA1, DATA2, SELECT shall be registered on acceptance; later input changes have no effect.
REQ-015 MUL ops: BUSY high from cycle after acceptance; VALID asserted exactly MUL_LATENCY cycles after acceptance edge; MUL returns low 32 bits, MULH/MULHSU/MULHU upper 32 bits of signed*signed, signed*unsigned, unsigned*unsigned 64-bit product.
REQ-016 DIV ops (non-special): restoring radix-2, one quotient bit per cycle; 1 setup cycle (operand absolute values), 32 iteration cycles, 1 sign-fixup cycle; VALID 34 cycles after acceptance.
REQ-017 Signed quotient sign = sign(DATA1) XOR sign(DATA2); signed remainder sign = sign(DATA1).
REQ-018 Divide by zero (DATA2=0): DIV/DIVU -> 0xFFFFFFFF, REM/REMU -> DATA1; VALID 1 cycle after acceptance, no iterations.
REQ-019 Signed overflow (DIV/REM, DATA1=0x80000000, DATA2=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0; VALID 1 cycle after acceptance.
REQ-020 BUSY shall be high in MUL and DIV states, low in IDLE and DONE; VALID coincides with entry to DONE.
REQ-021 START accepted in the same cycle VALID is high shall be legal (back-to-back); new operation begins next cycle.
REQ-022 FLUSH in MUL or DIV: return to IDLE next cycle, BUSY low, no VALID, RESULT unchanged.
REQ-023 FLUSH and START in the same cycle: FLUSH wins, START dropped.
REQ-024 Iteration counter shall be 6 bits and never wrap during an operation.

Reset
REQ-025 RESET shall force IDLE, BUSY=0, VALID=0, RESULT=0x00000000, counter=0, operand registers=0.
REQ-026 RESET mid-operation shall abort it with no VALID; RESET overrides START and FLUSH.

Structure
REQ-027 SELECT opcodes, state encoding and DIV_CYCLES=32 constants shall live in a shared package used also by the ALU decode.
REQ-028 Iterative divide datapath (remainder/quotient shift registers, subtract-compare) shall be sub-module div_iter; multiply pipeline and FSM stay in alu_muldiv_ctrl.

Verification
REQ-029 MUL DATA1=0x00000007, DATA2=0xFFFFFFFD -> VALID at cycle 2, RESULT=0xFFFFFFEB; MULHU same operands -> 0x00000006.
REQ-030 DIV DATA1=0xFFFFFFF9 (-7), DATA2=2 -> VALID at cycle 34, RESULT=0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-031 DIVU DATA1=0x12345678, DATA2=0 -> VALID at cycle 1, RESULT=0xFFFFFFFF; REMU -> 0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at cycle 1.
REQ-032 DIV started, FLUSH at cycle 10 -> BUSY low at cycle 11, no VALID; START with FLUSH same cycle -> not accepted.
REQ-033 START while BUSY with different operands -> ignored, original result delivered; START on VALID cycle -> second op VALID at expected latency.
REQ-034 RESET at cycle 20 of DIV -> next cycle BUSY=0, VALID=0, RESULT=0; following MUL completes normally.
